// File: rtl/cam_pixel_assembler.sv
// cam_pixel_assembler
// Rebuilds 16-bit RGB565 pixels from a byte-serial camera bus (vsync/href/data).
// Tags each pixel with start-of-frame, end-of-line and end-of-frame flags.
// Buffers the pixels in a small first-word-fall-through FIFO and hands them out
// over a valid/ready handshake. Malformed frames are reported at frame end.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   cam_vsync, cam_href   - camera frame / line framing (sampled every clk)
//   cam_data, cam_byte_en - camera byte and its one-cycle qualifier
//   pixel_out/sof/eol/eof - FIFO head pixel and its tags
//   pixel_valid           - FIFO not empty
//   pixel_ready           - consumer accepts the head pixel
//   frame_err             - one-cycle pulse at the end of a malformed frame
//   overflow              - sticky: a pixel was dropped on a full FIFO
//   frame_count           - completed frames, wrapping
module cam_pixel_assembler #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        cam_byte_en,
  output logic [15:0] pixel_out,
  output logic        pixel_sof,
  output logic        pixel_eol,
  output logic        pixel_eof,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 2);

  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] Y_SAT  = YW'(V_ACTIVE + 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    BLANK      = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic            phase_q, phase_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic [XW-1:0]   x_cnt_q, x_cnt_d;
  logic [YW-1:0]   y_cnt_q, y_cnt_d;
  logic            line_bad_q, line_bad_d;
  logic            frame_bad_q, frame_bad_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [18:0]     mem_q [FIFO_DEPTH];
  logic [18:0]     mem_d [FIFO_DEPTH];

  logic            vsync_rise, vsync_fall, href_fall;
  logic            fifo_full, pop, push_req, push_ok;
  logic [18:0]     push_entry, head;

  assign vsync_rise  = cam_vsync & ~vsync_q;
  assign vsync_fall  = ~cam_vsync & vsync_q;
  assign href_fall   = ~cam_href & href_q;
  assign pixel_valid = (count_q != {CW{1'b0}});
  assign fifo_full   = (count_q == FULL);
  assign pop         = pixel_valid & pixel_ready;
  assign head        = mem_q[rd_ptr_q];

  // Outputs read straight from the head entry; zero while the FIFO is empty.
  assign pixel_out   = pixel_valid ? head[15:0] : 16'd0;
  assign pixel_eof   = pixel_valid & head[16];
  assign pixel_eol   = pixel_valid & head[17];
  assign pixel_sof   = pixel_valid & head[18];
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

  // Framing state machine, byte assembly, bounds and frame-quality tracking.
  always_comb begin
    state_d       = state_q;
    vsync_d       = cam_vsync;
    href_d        = cam_href;
    phase_d       = phase_q;
    hi_byte_d     = hi_byte_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    line_bad_d    = line_bad_q;
    frame_bad_d   = frame_bad_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    frame_err_d   = 1'b0;
    push_req      = 1'b0;
    push_ok       = 1'b0;
    push_entry    = 19'd0;
    case (state_q)
      WAIT_VSYNC: begin
        // Only a vsync rise proves we are between frames again.
        if (vsync_rise) state_d = BLANK;
        else            state_d = WAIT_VSYNC;
      end
      BLANK: begin
        if (vsync_fall) begin
          x_cnt_d     = {XW{1'b0}};
          y_cnt_d     = {YW{1'b0}};
          frame_bad_d = 1'b0;
          line_bad_d  = 1'b0;
          phase_d     = 1'b0;
          state_d     = ACTIVE;
        end else begin
          state_d = BLANK;
        end
      end
      ACTIVE: begin
        if (cam_byte_en && cam_href) begin
          if (phase_q == 1'b0) begin
            hi_byte_d = cam_data;
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_cnt_q < X_END) x_cnt_d = x_cnt_q + XW'(1'b1);
            else                 x_cnt_d = x_cnt_q;
            if ((x_cnt_q < X_END) && (y_cnt_q < Y_END)) begin
              push_req   = 1'b1;
              push_entry = {((x_cnt_q == {XW{1'b0}}) && (y_cnt_q == {YW{1'b0}})),
                            (x_cnt_q == X_LAST),
                            ((x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST)),
                            hi_byte_q, cam_data};
            end else begin
              line_bad_d = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q;
        end
        // A full FIFO takes a new pixel only if the head leaves this cycle.
        if (push_req) begin
          if (!fifo_full || pop) begin
            push_ok = 1'b1;
          end else begin
            push_ok     = 1'b0;
            overflow_d  = 1'b1;
            frame_bad_d = 1'b1;
          end
        end else begin
          push_ok = 1'b0;
        end
        // Line end is folded in before any frame-end check in the same cycle.
        if (href_fall) begin
          frame_bad_d = frame_bad_d | line_bad_q | phase_q | (x_cnt_q != X_END);
          line_bad_d  = 1'b0;
          x_cnt_d     = {XW{1'b0}};
          phase_d     = 1'b0;
          if (y_cnt_q != Y_SAT) y_cnt_d = y_cnt_q + YW'(1'b1);
          else                  y_cnt_d = y_cnt_q;
        end else begin
          y_cnt_d = y_cnt_q;
        end
        if (vsync_rise) begin
          frame_err_d   = frame_bad_d | (y_cnt_d != Y_END);
          frame_count_d = frame_count_q + 16'd1;
          state_d       = BLANK;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = WAIT_VSYNC;
      end
    endcase
  end

  // FIFO pointer, occupancy and storage update.
  always_comb begin
    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1'b1);
    else     rd_ptr_d = rd_ptr_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1'b1);
    else if (!push_ok && pop) count_d = count_q - CW'(1'b1);
    else                      count_d = count_q;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_VSYNC;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      phase_q       <= 1'b0;
      hi_byte_q     <= 8'd0;
      x_cnt_q       <= {XW{1'b0}};
      y_cnt_q       <= {YW{1'b0}};
      line_bad_q    <= 1'b0;
      frame_bad_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= 16'd0;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 19'd0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_bad_q    <= line_bad_d;
      frame_bad_q   <= frame_bad_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Testbench for cam_pixel_assembler with a small frame geometry.
// A frame-level reference model (byte counts per line, a bounded pixel queue)
// predicts every output each cycle; per-frame totals are also checked against
// constants derived from the frame shape.
module tb_cam_pixel_assembler;
  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset, cam_vsync, cam_href, cam_byte_en, pixel_ready;
  logic [7:0]  cam_data;
  logic [15:0] pixel_out, frame_count;
  logic        pixel_sof, pixel_eol, pixel_eof, pixel_valid, frame_err, overflow;

  always #5 clk = ~clk;

  cam_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cam_byte_en(cam_byte_en), .pixel_out(pixel_out),
    .pixel_sof(pixel_sof), .pixel_eol(pixel_eol), .pixel_eof(pixel_eof),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .frame_err(frame_err),
    .overflow(overflow), .frame_count(frame_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [18:0] mq[$];
  bit          m_synced, m_active, m_frame_bad, m_ovf, m_ferr, prev_vs, prev_hr;
  int          m_line, m_bytes;
  logic [7:0]  m_hi;
  logic [15:0] m_fc;

  int rdy_mode, cur_line;
  int pops, eols, sofs, eofs, errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs, advance the model.
  task automatic drive(input bit rst, input bit vs, input bit hr, input bit be, input logic [7:0] d);
    bit rdy;
    int k;
    logic [18:0] e;
    case (rdy_mode)
      1:       rdy = ($urandom_range(0, 3) != 0);
      2:       rdy = (cur_line != 1);
      default: rdy = 1'b1;
    endcase
    reset = rst; cam_vsync = vs; cam_href = hr; cam_byte_en = be; cam_data = d; pixel_ready = rdy;
    if (!rst) begin
      chk("valid", 32'(pixel_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("head", 32'({pixel_sof, pixel_eol, pixel_eof, pixel_out}), 32'(mq[0]));
      else                chk("idle_out", 32'({pixel_sof, pixel_eol, pixel_eof, pixel_out}), 32'd0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
      if (pixel_valid && rdy) begin
        pops++;
        if (pixel_sof) sofs++;
        if (pixel_eol) eols++;
        if (pixel_eof) eofs++;
      end
      if (frame_err) errs++;
    end
    if (rst) begin
      mq.delete();
      m_synced = 0; m_active = 0; m_frame_bad = 0; m_ovf = 0; m_ferr = 0;
      prev_vs = 0; prev_hr = 0; m_fc = 16'd0; m_line = 0; m_bytes = 0;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      m_ferr = 0;
      if (m_active && be && hr) begin
        if (m_bytes % 2 == 0) begin
          m_hi = d;
        end else begin
          k = m_bytes / 2;
          if (k < H && m_line < V) begin
            e = {(k == 0 && m_line == 0), (k == H - 1), (k == H - 1 && m_line == V - 1), m_hi, d};
            if (mq.size() < D) mq.push_back(e);
            else begin m_ovf = 1; m_frame_bad = 1; end
          end
        end
        m_bytes++;
      end
      if (m_active && !hr && prev_hr) begin
        if (m_bytes != 2 * H) m_frame_bad = 1;
        m_line++;
        m_bytes = 0;
      end
      if (vs && !prev_vs) begin
        if (m_active) begin
          m_ferr = m_frame_bad || (m_line != V);
          m_fc++;
          m_active = 0;
        end
        m_synced = 1;
      end else if (!vs && prev_vs && m_synced && !m_active) begin
        m_active = 1; m_line = 0; m_bytes = 0; m_frame_bad = 0;
      end
      prev_vs = vs; prev_hr = hr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One frame: vsync fall, lines (one may have a custom byte count), vsync rise and drain.
  task automatic run_frame(input int nlines, input int odd_line, input int odd_bytes,
                           input int rmode, input int rst_line, input bit rnd);
    logic [7:0] dat;
    int n;
    pops = 0; eols = 0; sofs = 0; eofs = 0; errs = 0;
    rdy_mode = rmode; cur_line = -1;
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int y = 0; y < nlines; y++) begin
      n = (y == odd_line) ? odd_bytes : 2 * H;
      cur_line = y;
      for (int b = 0; b < n; b++) begin
        if (rnd) repeat ($urandom_range(0, 1)) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        if (rnd) dat = 8'($urandom);
        else     dat = (b % 2 == 0) ? 8'hAB : 8'hCD;
        drive(1'b0, 1'b0, 1'b1, 1'b1, dat);
      end
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (y == rst_line) repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    cur_line = -1;
    rdy_mode = 0;
    repeat (12) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; cam_vsync = 1'b1; cam_href = 1'b0; cam_byte_en = 1'b0;
    cam_data = 8'h00; pixel_ready = 1'b1; rdy_mode = 0; cur_line = -1;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_valid", 32'(pixel_valid), 32'd0);
    chk("rst_pixel", 32'(pixel_out), 32'd0);
    chk("rst_flags", 32'({pixel_sof, pixel_eol, pixel_eof, frame_err, overflow}), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Nominal frame, fixed bytes, ready always high.
    run_frame(V, -1, 0, 0, -1, 1'b0);
    chk("nom_pops", pops, H * V);
    chk("nom_sof", sofs, 1);
    chk("nom_eol", eols, V);
    chk("nom_eof", eofs, 1);
    chk("nom_err", errs, 0);
    chk("nom_fc", 32'(frame_count), 32'd1);

    // Random data, byte gaps and random backpressure that never overflows a clean frame check.
    run_frame(V, -1, 0, 1, -1, 1'b1);
    chk("rnd_fc", 32'(frame_count), 32'd2);

    // Short line: one pixel missing on line 1.
    run_frame(V, 1, 2 * H - 2, 0, -1, 1'b0);
    chk("short_pops", pops, H * V - 1);
    chk("short_err", errs, 1);
    chk("short_fc", 32'(frame_count), 32'd3);

    // Line 0 carries an extra pixel plus an odd byte.
    run_frame(V, 0, 2 * H + 3, 0, -1, 1'b0);
    chk("odd_pops", pops, H * V);
    chk("odd_err", errs, 1);

    // Extra line beyond V_ACTIVE.
    run_frame(V + 1, -1, 0, 0, -1, 1'b0);
    chk("xline_pops", pops, H * V);
    chk("xline_err", errs, 1);

    // Backpressure over a whole line: four pixels kept, four dropped.
    run_frame(V, -1, 0, 2, -1, 1'b0);
    chk("bp_pops", pops, H * V - D);
    chk("bp_err", errs, 1);
    chk("bp_ovf", 32'(overflow), 32'd1);

    // Reset in the middle of a frame; the remainder must be ignored.
    run_frame(V, -1, 0, 0, 1, 1'b0);
    chk("rstmid_fc", 32'(frame_count), 32'd0);
    chk("rstmid_ovf", 32'(overflow), 32'd0);
    chk("rstmid_err", errs, 0);

    // Following frame is captured cleanly.
    run_frame(V, -1, 0, 0, -1, 1'b0);
    chk("post_pops", pops, H * V);
    chk("post_err", errs, 0);
    chk("post_fc", 32'(frame_count), 32'd1);

    // A random frame with random backpressure; the model tracks any drops.
    run_frame(V, -1, 0, 1, -1, 1'b1);
    chk("final_fc", 32'(frame_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
